uart_rx_deserializer: RTL and testbench

Serial-to-parallel receive stage of the UART link; consumes the single-bit line driven by the transmitter and feeds the 8-bit byte to the binary-to-BCD separator.
Synchronises the asynchronous line, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit.
Checks the stop bit and presents each byte with a one-cycle valid strobe; bad frames are flagged, not delivered.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx_deserializer.sv | 155 +++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, frame geometry and a width helper.
// Used by both the receive deserializer and the transmitter.
package uart_pkg;

    // Frame FSM states, 2-bit encoding shared by RX and TX.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Data bits per frame. The datapath is built for exactly 8.
    localparam int DATA_BITS        = 8;

    // 50 MHz system clock divided down to 9600 baud.
    localparam int CLKS_PER_BIT_DEF = 5208;

    // Ceiling log2, minimum 1, for sizing counters that hold 0 .. v-1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Reset value is a parameter so an idle-high line comes out of reset idle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iD,
    output logic oQ
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= iD;
            sync_q <= meta_q;
        end
    end

    assign oQ = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive stage: synchronises the serial line, validates the start bit,
// samples 8 data bits LSB-first at mid-bit and checks the stop bit.
//
// Output strobes: oValid is a single-cycle pulse and oData carries the new
// byte in that same cycle; oData then holds until the next good frame. There
// is no ready/back-pressure: the consumer must take the byte on the pulse.
// oFrameErr is a single-cycle pulse for a low stop bit and never coincides
// with oValid; a bad frame leaves oData untouched.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iRx,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oFrameErr,
    output logic       oBusy
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam int IDX_W = clog2(DATA_BITS);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    // Below 4 clocks per bit the mid-bit sample point collapses onto the edge.
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx_deserializer: CLKS_PER_BIT must be >= 4");
    end

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q,  data_d;
    logic             valid_q, valid_d;
    logic             ferr_q,  ferr_d;
    logic             hist_q;
    logic             rx_s;
    logic             fall;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iD     (iRx),
        .oQ     (rx_s)
    );

    // History flop runs in every state so a start edge landing right as
    // STOP hands back to IDLE is still seen.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= rx_s;
        end
    end

    assign fall = hist_q & ~rx_s;

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame sequencing; the baud counter restarts on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high level was a glitch.
                if (cnt_q == CNT_MID) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                // Right shift: the first (LSB) bit ends up in shift[0].
                if (cnt_q == CNT_LAST) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d != state_q) || (state_q == IDLE) || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign oData     = data_q;
    assign oValid    = valid_q;
    assign oFrameErr = ferr_q;
    assign oBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 8 clocks per bit.
module tb_uart_rx_deserializer;

    localparam int CPB      = 8;
    localparam int HALF     = CPB / 2;
    localparam int LAT_NOM  = 2 + HALF + 9 * CPB;
    localparam int FRAME_CY = 10 * CPB;

    // ---------------- clock / reset ----------------
    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iRx;
    logic [7:0] oData;
    logic       oValid;
    logic       oFrameErr;
    logic       oBusy;

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    uart_rx_deserializer #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iRx       (iRx),
        .oData     (oData),
        .oValid    (oValid),
        .oFrameErr (oFrameErr),
        .oBusy     (oBusy)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    int   n_valid    = 0;
    int   n_ferr     = 0;
    int   last_vcyc  = 0;
    int   prev_vcyc  = 0;
    logic prev_valid = 1'b0;

    always @(negedge iClk) begin
        if (iRst_n === 1'b1) begin
            if (oValid) begin
                n_valid++;
                prev_vcyc = last_vcyc;
                last_vcyc = cyc;
                check("valid_width", {31'b0, prev_valid}, 0);
                check("valid_ferr_excl", {31'b0, oFrameErr}, 0);
                check("sb_pending", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    check("sb_data", {24'b0, oData}, {24'b0, exp_q.pop_front()});
                end
            end
            if (oFrameErr) begin
                n_ferr++;
            end
            prev_valid = oValid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int fall_cyc);
        iRx      = 1'b0;
        fall_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            iRx = b[i];
            tick(CPB);
        end
        iRx = stop_bit;
        tick(CPB);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int f;
        int nv;
        int nf;
        logic [7:0] b55;

        // Reset with the line toggling.
        iRst_n = 1'b0;
        iRx    = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            iRx = ~iRx;
            tick(1);
        end
        check("rst_data",  {24'b0, oData}, 0);
        check("rst_valid", {31'b0, oValid}, 0);
        check("rst_ferr",  {31'b0, oFrameErr}, 0);
        check("rst_busy",  {31'b0, oBusy}, 0);
        iRx = 1'b1;
        tick(2);
        iRst_n = 1'b1;
        tick(200);
        check("idle_no_valid", n_valid, 0);
        check("idle_no_ferr",  n_ferr, 0);
        check("idle_busy",     {31'b0, oBusy}, 0);

        // Single frame A5.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, f);
        tick(4);
        check("a5_count", n_valid, 1);
        check("a5_data",  {24'b0, oData}, 32'hA5);
        check("a5_ferr",  n_ferr, 0);
        check("a5_busy",  {31'b0, oBusy}, 0);
        check("a5_latency_pm1",
              ((last_vcyc - f >= LAT_NOM - 1) && (last_vcyc - f <= LAT_NOM + 1)) ? 1 : 0, 1);

        // Back-to-back 00 then FF, no idle gap.
        tick(8);
        nv = n_valid;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, f);
        send_frame(8'hFF, 1'b1, f);
        tick(4);
        check("b2b_count",   n_valid - nv, 2);
        check("b2b_spacing", last_vcyc - prev_vcyc, FRAME_CY);
        check("b2b_data",    {24'b0, oData}, 32'hFF);

        // Glitch: two cycles low is rejected in START.
        tick(8);
        nv = n_valid;
        nf = n_ferr;
        iRx = 1'b0;
        tick(2);
        iRx = 1'b1;
        tick(1);
        check("glitch_busy_hi", {31'b0, oBusy}, 1);
        tick(HALF + 2);
        check("glitch_busy_lo", {31'b0, oBusy}, 0);
        tick(20);
        check("glitch_no_valid", n_valid - nv, 0);
        check("glitch_no_ferr",  n_ferr - nf, 0);
        check("glitch_data",     {24'b0, oData}, 32'hFF);

        // Framing error on 3C, line held low (break), then frame 12.
        nv = n_valid;
        nf = n_ferr;
        send_frame(8'h3C, 1'b0, f);
        tick(30);
        check("ferr_count",    n_ferr - nf, 1);
        check("ferr_no_valid", n_valid - nv, 0);
        check("ferr_data_hold", {24'b0, oData}, 32'hFF);
        check("break_no_rearm", {31'b0, oBusy}, 0);
        iRx = 1'b1;
        tick(16);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, f);
        tick(4);
        check("after_ferr_count", n_valid - nv, 1);
        check("after_ferr_data",  {24'b0, oData}, 32'h12);

        // Reset during bit 4 of 55.
        tick(8);
        nv  = n_valid;
        nf  = n_ferr;
        b55 = 8'h55;
        iRx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            iRx = b55[i];
            tick(CPB);
        end
        iRx = b55[4];
        tick(HALF);
        check("mid_busy_before", {31'b0, oBusy}, 1);
        iRst_n = 1'b0;
        #1;
        check("mid_rst_busy",  {31'b0, oBusy}, 0);
        check("mid_rst_data",  {24'b0, oData}, 0);
        check("mid_rst_valid", {31'b0, oValid}, 0);
        tick(3);
        iRx = 1'b1;
        tick(1);
        iRst_n = 1'b1;
        tick(CPB * 8);
        check("mid_no_valid", n_valid - nv, 0);
        check("mid_no_ferr",  n_ferr - nf, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, f);
        tick(4);
        check("mid_next_count", n_valid - nv, 1);
        check("mid_next_data",  {24'b0, oData}, 32'h55);

        tick(10);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
